// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef logic [1:0] haz_state_t;
  localparam haz_state_t RUN      = 2'd0;
  localparam haz_state_t MEM_WAIT = 2'd1;
  localparam haz_state_t FLUSH    = 2'd2;

  localparam logic [4:0] XZR = 5'd31;
endpackage

// File: rtl/reg_match.sv
// Register-match comparator: hit when a writer targets the read register (XZR never hits).
module reg_match
  import hazard_pkg::*;
(
  input  logic [4:0] a,
  input  logic [4:0] b,
  input  logic       we,
  output logic       hit
);
  assign hit = we && (a == b) && (a != XZR);
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use interlock, memory stall, branch flush.
// HAZ_STATS_EN adds saturating stall/flush cycle counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       id_valid,
  input  logic [4:0] Rn_ID,
  input  logic [4:0] Rm_ID,
  input  logic       uses_Rm_ID,
  input  logic [4:0] Rn_EX,
  input  logic [4:0] Rm_EX,
  input  logic [4:0] Rd_EX,
  input  logic       RegWrite_EX,
  input  logic       MemRead_EX,
  input  logic [4:0] Rd_MEM,
  input  logic       RegWrite_MEM,
  input  logic       MemReq_MEM,
  input  logic       mem_ready,
  input  logic [4:0] Rd_WB,
  input  logic       RegWrite_WB,
  input  logic       br_taken_EX,
  output logic [1:0] ForwardA,
  output logic [1:0] ForwardB,
  output logic       stall_pc,
  output logic       stall_ifid,
  output logic       stall_idex,
  output logic       stall_exmem,
  output logic       bubble_ex,
  output logic       bubble_wb,
  output logic       flush_ifid
`ifdef HAZ_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);
  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] RELOAD = FC_W'(FLUSH_CYCLES - 1);

  // Comparator slots: 0/1 ForwardA MEM/WB, 2/3 ForwardB MEM/WB, 4/5 load-use Rn/Rm.
  logic [5:0][4:0] mA, mB;
  logic [5:0]      mWe, mHit;

  assign mA  = {Rm_ID, Rn_ID, Rm_EX, Rm_EX, Rn_EX, Rn_EX};
  assign mB  = {Rd_EX, Rd_EX, Rd_WB, Rd_MEM, Rd_WB, Rd_MEM};
  assign mWe = {RegWrite_EX, RegWrite_EX, RegWrite_WB, RegWrite_MEM, RegWrite_WB, RegWrite_MEM};

  reg_match uMatch [5:0] (.a(mA), .b(mB), .we(mWe), .hit(mHit));

  fwd_sel_t fwdA, fwdB;
  always_comb begin
    fwdA = FWD_REG;
    fwdB = FWD_REG;
    if (reset_n) begin
      if (mHit[0])      fwdA = FWD_MEM;
      else if (mHit[1]) fwdA = FWD_WB;
      if (mHit[2])      fwdB = FWD_MEM;
      else if (mHit[3]) fwdB = FWD_WB;
    end
  end
  assign ForwardA = fwdA;
  assign ForwardB = fwdB;

  haz_state_t       st, stNext;
  logic [FC_W-1:0]  cnt, cntNext;
  logic             brPend, brPendNext;
  logic             luHold;
  logic             miss, brAny, loadUse;
  logic             stallMem, luStall, flush, bubEx;

  assign miss    = MemReq_MEM && !mem_ready;
  assign brAny   = br_taken_EX || brPend;
  assign loadUse = id_valid && MemRead_EX && (mHit[4] || (uses_Rm_ID && mHit[5]));

  always_comb begin
    stNext     = st;
    cntNext    = cnt;
    brPendNext = brPend;
    stallMem   = 1'b0;
    luStall    = 1'b0;
    flush      = 1'b0;
    bubEx      = 1'b0;
    case (st)
      RUN: begin
        if (miss) begin
          stallMem   = 1'b1;
          brPendNext = brAny;
          stNext     = MEM_WAIT;
        end else if (brAny) begin
          flush      = 1'b1;
          bubEx      = 1'b1;
          brPendNext = 1'b0;
          if (FLUSH_CYCLES > 1) begin
            cntNext = RELOAD;
            stNext  = FLUSH;
          end
        end else if (loadUse && !luHold) begin
          // luHold models the bubble the stall just pushed into EX
          luStall = 1'b1;
          bubEx   = 1'b1;
        end
      end
      MEM_WAIT: begin
        // EX is frozen, so a branch seen here is remembered for after the wait
        brPendNext = brAny;
        if (!mem_ready) stallMem = 1'b1;
        else            stNext   = (cnt != '0) ? FLUSH : RUN;
      end
      FLUSH: begin
        if (miss) begin
          stallMem   = 1'b1;
          brPendNext = brAny;
          stNext     = MEM_WAIT;
        end else if (brAny) begin
          flush      = 1'b1;
          brPendNext = 1'b0;
          cntNext    = RELOAD;
          if (FLUSH_CYCLES <= 1) stNext = RUN;
        end else begin
          flush = 1'b1;
          if (cnt <= FC_W'(1)) begin
            cntNext = '0;
            stNext  = RUN;
          end else begin
            cntNext = cnt - FC_W'(1);
          end
        end
      end
      default: stNext = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st     <= RUN;
      cnt    <= '0;
      brPend <= 1'b0;
      luHold <= 1'b0;
    end else begin
      st     <= stNext;
      cnt    <= cntNext;
      brPend <= brPendNext;
      luHold <= luStall;
    end
  end

  assign stall_pc    = reset_n && (stallMem || luStall);
  assign stall_ifid  = reset_n && (stallMem || luStall);
  assign stall_idex  = reset_n && stallMem;
  assign stall_exmem = reset_n && stallMem;
  assign bubble_wb   = reset_n && stallMem;
  assign bubble_ex   = reset_n && bubEx;
  assign flush_ifid  = reset_n && flush;

`ifdef HAZ_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_pc && (stall_cnt != '1))   stall_cnt <= stall_cnt + 1'b1;
      if (flush_ifid && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized run against a cycle model.
module tb_hazard_ctrl;
  localparam int FC = 2;
  localparam int CW = 2;
  // {stall_pc, stall_ifid, stall_idex, stall_exmem, bubble_ex, bubble_wb, flush_ifid}
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_MEM  = 7'b1111010;
  localparam logic [6:0] C_LU   = 7'b1100100;
  localparam logic [6:0] C_BR   = 7'b0000101;
  localparam logic [6:0] C_FL   = 7'b0000001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, id_valid, uses_Rm_ID, RegWrite_EX, MemRead_EX, RegWrite_MEM, MemReq_MEM;
  logic mem_ready, RegWrite_WB, br_taken_EX;
  logic [4:0] Rn_ID, Rm_ID, Rn_EX, Rm_EX, Rd_EX, Rd_MEM, Rd_WB;
  logic [1:0] ForwardA, ForwardB;
  logic stall_pc, stall_ifid, stall_idex, stall_exmem, bubble_ex, bubble_wb, flush_ifid;
`ifdef HAZ_STATS_EN
  logic [CW-1:0] stall_cnt, flush_cnt;
`endif
  wire [6:0] ctl = {stall_pc, stall_ifid, stall_idex, stall_exmem, bubble_ex, bubble_wb, flush_ifid};

  int checks = 0, passes = 0;

  hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .Rn_ID(Rn_ID), .Rm_ID(Rm_ID),
    .uses_Rm_ID(uses_Rm_ID), .Rn_EX(Rn_EX), .Rm_EX(Rm_EX), .Rd_EX(Rd_EX),
    .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX), .Rd_MEM(Rd_MEM),
    .RegWrite_MEM(RegWrite_MEM), .MemReq_MEM(MemReq_MEM), .mem_ready(mem_ready),
    .Rd_WB(Rd_WB), .RegWrite_WB(RegWrite_WB), .br_taken_EX(br_taken_EX),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .stall_pc(stall_pc), .stall_ifid(stall_ifid),
    .stall_idex(stall_idex), .stall_exmem(stall_exmem), .bubble_ex(bubble_ex),
    .bubble_wb(bubble_wb), .flush_ifid(flush_ifid)
`ifdef HAZ_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  // ---- reference model: owed flush cycles, owed branch, memory-busy flag ----
  bit mBusy, mOwedBr, mPrevLU;
  int mRem;

  function automatic bit match(logic [4:0] r, logic [4:0] d, logic we);
    return we && (r == d) && (r != 5'd31);
  endfunction

  function automatic logic [1:0] fwd(logic [4:0] r);
    if (!reset_n) return 2'b00;
    if (match(r, Rd_MEM, RegWrite_MEM)) return 2'b10;
    if (match(r, Rd_WB, RegWrite_WB)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_step(output logic [6:0] e);
    bit mem, exitc, br, lu, luNow;
    e = C_NONE;
    if (!reset_n) begin
      mBusy = 0; mOwedBr = 0; mRem = 0; mPrevLU = 0;
      return;
    end
    br    = br_taken_EX || mOwedBr;
    mem   = (mBusy || MemReq_MEM) && !mem_ready;
    exitc = mBusy && mem_ready;
    lu    = id_valid && MemRead_EX && (match(Rn_ID, Rd_EX, RegWrite_EX) ||
            (uses_Rm_ID && match(Rm_ID, Rd_EX, RegWrite_EX)));
    luNow = 0;
    if (mem || exitc) begin
      mOwedBr = br;
      if (mem) e = C_MEM;
    end else if (br) begin
      e = (mRem == 0) ? C_BR : C_FL;
      mOwedBr = 0;
      mRem = FC - 1;
    end else if (mRem > 0) begin
      e = C_FL;
      mRem--;
    end else if (lu && !mPrevLU) begin
      e = C_LU;
      luNow = 1;
    end
    mPrevLU = luNow;
    mBusy = mem;
  endtask

  // ---- stimulus helpers ----
  task automatic idle();
    id_valid = 0; uses_Rm_ID = 0; RegWrite_EX = 0; MemRead_EX = 0; RegWrite_MEM = 0;
    MemReq_MEM = 0; mem_ready = 0; RegWrite_WB = 0; br_taken_EX = 0;
    Rn_ID = 0; Rm_ID = 0; Rn_EX = 0; Rm_EX = 0; Rd_EX = 0; Rd_MEM = 0; Rd_WB = 0;
  endtask
  task automatic nxt(); @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); endtask

  task automatic test_reset();
    idle();
    reset_n = 0;
    Rn_EX = 3; Rd_MEM = 3; RegWrite_MEM = 1; MemReq_MEM = 1; br_taken_EX = 1;
    nxt(); nxt(); smp();
    checks++; if (ctl !== C_NONE) $display("FAIL reset_ctl got %b want %b", ctl, C_NONE); else passes++;
    checks++; if (ForwardA !== 2'b00) $display("FAIL reset_fwdA got %b want 00", ForwardA); else passes++;
    nxt(); idle(); reset_n = 1;
  endtask

  task automatic test_forward();
    Rd_MEM = 3; RegWrite_MEM = 1; Rd_WB = 3; RegWrite_WB = 1; Rn_EX = 3; #1;
    checks++; if (ForwardA !== 2'b10) $display("FAIL fwd_mem got %b want 10", ForwardA); else passes++;
    Rd_MEM = 31; #1;
    checks++; if (ForwardA !== 2'b01) $display("FAIL fwd_wb got %b want 01", ForwardA); else passes++;
    Rn_EX = 31; Rd_WB = 31; #1;
    checks++; if (ForwardA !== 2'b00) $display("FAIL fwd_xzr got %b want 00", ForwardA); else passes++;
    Rm_EX = 7; Rd_MEM = 7; Rd_WB = 7; RegWrite_MEM = 0; #1;
    checks++; if (ForwardB !== 2'b01) $display("FAIL fwdB_wb got %b want 01", ForwardB); else passes++;
    RegWrite_MEM = 1; #1;
    checks++; if (ForwardB !== 2'b10) $display("FAIL fwdB_mem got %b want 10", ForwardB); else passes++;
    nxt(); idle();
  endtask

  task automatic test_load_use();
    MemRead_EX = 1; RegWrite_EX = 1; Rd_EX = 5; Rm_ID = 5; uses_Rm_ID = 1; id_valid = 1;
    smp();
    checks++; if (ctl !== C_LU) $display("FAIL lu_stall got %b want %b", ctl, C_LU); else passes++;
    nxt(); smp();
    checks++; if (ctl !== C_NONE) $display("FAIL lu_once got %b want %b", ctl, C_NONE); else passes++;
    nxt(); uses_Rm_ID = 0; smp();
    checks++; if (ctl !== C_NONE) $display("FAIL lu_noRm got %b want %b", ctl, C_NONE); else passes++;
    nxt(); Rn_ID = 5; smp();
    checks++; if (ctl !== C_LU) $display("FAIL lu_Rn got %b want %b", ctl, C_LU); else passes++;
    nxt(); idle();
  endtask

  task automatic test_mem_stall();
    MemReq_MEM = 1;
    for (int i = 0; i < 4; i++) begin
      smp();
      checks++; if (ctl !== C_MEM) $display("FAIL mem_wait%0d got %b want %b", i, ctl, C_MEM); else passes++;
      nxt();
    end
    mem_ready = 1; smp();
    checks++; if (ctl !== C_NONE) $display("FAIL mem_done got %b want %b", ctl, C_NONE); else passes++;
    nxt(); idle(); br_taken_EX = 1; smp();
    checks++; if (ctl !== C_BR) $display("FAIL mem_back_run got %b want %b", ctl, C_BR); else passes++;
    nxt(); idle(); nxt(); nxt();
  endtask

  task automatic test_branch();
    br_taken_EX = 1; MemRead_EX = 1; RegWrite_EX = 1; Rd_EX = 4; Rn_ID = 4; id_valid = 1;
    smp();
    checks++; if (ctl !== C_BR) $display("FAIL br_first got %b want %b", ctl, C_BR); else passes++;
    nxt(); br_taken_EX = 0; smp();
    checks++; if (ctl !== C_FL) $display("FAIL br_second got %b want %b", ctl, C_FL); else passes++;
    nxt(); idle(); smp();
    checks++; if (ctl !== C_NONE) $display("FAIL br_done got %b want %b", ctl, C_NONE); else passes++;
    // miss arriving mid-flush preempts and the remaining flush cycle resumes afterwards
    nxt(); br_taken_EX = 1; smp();
    nxt(); br_taken_EX = 0; MemReq_MEM = 1; smp();
    checks++; if (ctl !== C_MEM) $display("FAIL brm_preempt got %b want %b", ctl, C_MEM); else passes++;
    nxt(); mem_ready = 1; smp();
    checks++; if (ctl !== C_NONE) $display("FAIL brm_exit got %b want %b", ctl, C_NONE); else passes++;
    nxt(); idle(); smp();
    checks++; if (ctl !== C_FL) $display("FAIL brm_resume got %b want %b", ctl, C_FL); else passes++;
    nxt(); smp();
    checks++; if (ctl !== C_NONE) $display("FAIL brm_end got %b want %b", ctl, C_NONE); else passes++;
    nxt();
  endtask

  task automatic test_branch_miss();
    br_taken_EX = 1; MemReq_MEM = 1; smp();
    checks++; if (ctl !== C_MEM) $display("FAIL bm_first got %b want %b", ctl, C_MEM); else passes++;
    nxt(); br_taken_EX = 0; smp();
    checks++; if (ctl !== C_MEM) $display("FAIL bm_wait got %b want %b", ctl, C_MEM); else passes++;
    nxt(); mem_ready = 1; smp();
    checks++; if (ctl !== C_NONE) $display("FAIL bm_exit got %b want %b", ctl, C_NONE); else passes++;
    nxt(); idle(); smp();
    checks++; if (ctl !== C_BR) $display("FAIL bm_flush got %b want %b", ctl, C_BR); else passes++;
    nxt(); smp();
    checks++; if (ctl !== C_FL) $display("FAIL bm_flush2 got %b want %b", ctl, C_FL); else passes++;
    nxt();
    // reset in the middle of a memory wait
    MemReq_MEM = 1; smp(); nxt(); reset_n = 0; smp();
    checks++; if (ctl !== C_NONE) $display("FAIL rst_mid got %b want %b", ctl, C_NONE); else passes++;
    nxt(); reset_n = 1; idle(); smp();
    checks++; if (ctl !== C_NONE) $display("FAIL rst_after got %b want %b", ctl, C_NONE); else passes++;
    nxt(); br_taken_EX = 1; smp();
    checks++; if (ctl !== C_BR) $display("FAIL rst_run got %b want %b", ctl, C_BR); else passes++;
    nxt(); idle(); nxt(); nxt();
  endtask

`ifdef HAZ_STATS_EN
  task automatic test_stats();
    reset_n = 0; nxt(); reset_n = 1; smp();
    checks++; if (stall_cnt !== '0) $display("FAIL stats_rst got %0d want 0", stall_cnt); else passes++;
    MemReq_MEM = 1;
    repeat (5) nxt();
    mem_ready = 1; smp();
    checks++; if (stall_cnt !== 2'd3) $display("FAIL stats_sat got %0d want 3", stall_cnt); else passes++;
    checks++; if (flush_cnt !== 2'd0) $display("FAIL stats_flush got %0d want 0", flush_cnt); else passes++;
    nxt(); idle(); nxt();
  endtask
`endif

  task automatic test_random();
    logic [6:0] e;
    logic [4:0] rs[5];
    idle(); reset_n = 0; smp(); model_step(e); nxt(); reset_n = 1;
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < 5; k++) begin
        rs[k] = 5'($urandom_range(0, 4));
        if (rs[k] == 5'd4) rs[k] = 5'd31;
      end
      Rn_ID = rs[0]; Rm_ID = rs[1]; Rn_EX = rs[2]; Rm_EX = rs[3]; Rd_EX = rs[4];
      Rd_MEM = 5'($urandom_range(0, 3)); Rd_WB = 5'($urandom_range(0, 3));
      RegWrite_EX = 1'($urandom); RegWrite_MEM = 1'($urandom); RegWrite_WB = 1'($urandom);
      MemRead_EX = ($urandom_range(0, 2) == 0); id_valid = 1'($urandom); uses_Rm_ID = 1'($urandom);
      br_taken_EX = ($urandom_range(0, 7) == 0);
      MemReq_MEM = mBusy ? 1'b1 : ($urandom_range(0, 5) == 0);
      mem_ready = 1'($urandom);
      reset_n = ($urandom_range(0, 99) != 0);
      smp();
      checks++; if (ForwardA !== fwd(Rn_EX)) $display("FAIL rnd_fwdA@%0d got %b want %b", n, ForwardA, fwd(Rn_EX)); else passes++;
      checks++; if (ForwardB !== fwd(Rm_EX)) $display("FAIL rnd_fwdB@%0d got %b want %b", n, ForwardB, fwd(Rm_EX)); else passes++;
      model_step(e);
      checks++; if (ctl !== e) $display("FAIL rnd_ctl@%0d got %b want %b", n, ctl, e); else passes++;
      nxt();
    end
    idle(); reset_n = 1;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_mem_stall();
    test_branch();
    test_branch_miss();
`ifdef HAZ_STATS_EN
    test_stats();
`endif
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
